// File: rtl/dmem_arbiter_if.sv
// Request, response and memory-pin bundle shared by the two requesters, the arbiter and the data memory.
// valid/ready: a beat transfers on a rising edge where req_valid[i] & req_ready[i]; the requester
// holds valid and payload stable until then, or withdraws valid (legal, the request is dropped).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [1:0]        req_last;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_last, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_wd
    );

    modport master (
        output req_valid, req_we, req_last, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (port 0) and the
// host loader (port 1); grants are registered and bounded to MAX_BURST beats per ownership.
module dmem_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus,
    output logic [1:0]    dbg_state,
    output logic          dbg_rr_ptr
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam int               CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        ready;
    logic              mem_we;
    logic              owner;
    logic              fire;
    logic              rel;

    assign owner = (state_q == OWN1);
    assign fire  = (state_q != IDLE) && bus.req_valid[owner];

    // Memory pins follow the owner's payload; outside ownership they hold the last driven value.
    always_comb begin
        addr_d = addr_q;
        wd_d   = wd_q;
        mem_we = 1'b0;
        if (state_q != IDLE) begin
            addr_d = owner ? bus.req_addr1  : bus.req_addr0;
            wd_d   = owner ? bus.req_wdata1 : bus.req_wdata0;
            mem_we = fire & bus.req_we[owner];
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        ready       = 2'b00;
        rel         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid == 2'b11) begin
                    state_d = rr_ptr_q ? OWN1 : OWN0;
                end else if (bus.req_valid[0]) begin
                    state_d = OWN0;
                end else if (bus.req_valid[1]) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                ready = owner ? 2'b10 : 2'b01;
                if (fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (!bus.req_we[owner]) begin
                        rsp_valid_d = ready;
                        rsp_rdata_d = bus.mem_rd;
                    end
                end
                // An idle owner cycle gives the memory up just like a last or full-count beat.
                rel = !fire || bus.req_last[owner] || (beat_cnt_q == LAST_CNT);
                if (rel) begin
                    rr_ptr_d   = !owner;
                    beat_cnt_d = '0;
                    if (bus.req_valid[!owner]) begin
                        state_d = owner ? OWN0 : OWN1;
                    end else if (fire) begin
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            beat_cnt_q  <= '0;
            addr_q      <= '0;
            wd_q        <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = addr_d;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wd    = wd_d;
    assign dbg_state     = state_q;
    assign dbg_rr_ptr    = rr_ptr_q;
endmodule
